scan_signature_analyzer: RTL

- Downstream response compactor for the built-in self-test loop.
- Consumes the serial scan_out stream of the scan-chain under test and compresses a fixed window of shifted-out bits into a serial-input signature register (SISR).
- At window end, compares the signature against a golden value and reports pass/fail, replacing bit-by-bit waveform inspection.

---
 rtl/bist_pkg.sv | 16 +
 rtl/sisr_reg.sv | 43 ++++
 rtl/scan_signature_analyzer.sv | 105 ++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared BIST definitions: analyzer FSM state encoding and the default
// signature polynomial/seed, also used by the pattern-generator LFSR stage.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    CHECK   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // x^8 + x^4 + x^3 + x^2 + 1, with the implicit x^8 term dropped
  localparam logic [7:0] DEFAULT_POLY = 8'h1D;
  localparam logic [7:0] DEFAULT_SEED = 8'h00;

endpackage

// File: rtl/sisr_reg.sv
// Serial-input signature register: shifts left, folds the polynomial back in
// when the outgoing MSB is set, and XORs the serial input into bit 0.
module sisr_reg
  import bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
  parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // load takes priority so a restart never mixes in a stray scan bit
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (shift) begin
      q_d = {q_q[WIDTH-2:0], 1'b0}
          ^ (q_q[WIDTH-1] ? POLY : {WIDTH{1'b0}})
          ^ {{(WIDTH-1){1'b0}}, din};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/scan_signature_analyzer.sv
// BIST response compactor: folds a fixed window of qualified scan_out bits
// into a SISR and compares the final signature against a golden value.
module scan_signature_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY   = DEFAULT_POLY,
  parameter logic [WIDTH-1:0] SEED   = DEFAULT_SEED,
  parameter int               WINDOW = 32,
  parameter int               CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             scan_en,
  input  logic             scan_bit,
  input  logic [WIDTH-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] WinLast = CNT_W'(WINDOW);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             sisrLoad;
  logic             sisrShift;

  assign sisrLoad  = start && ((state_q == IDLE) || (state_q == DONE));
  assign sisrShift = (state_q == COMPACT) && scan_en;
  assign count_d   = count_q + CNT_W'(1);

  sisr_reg #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_sisr (
    .clk   (clk),
    .rst   (rst),
    .load  (sisrLoad),
    .shift (sisrShift),
    .din   (scan_bit),
    .q     (signature)
  );

  // A start edge only arms the run; the first bit is taken on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= COMPACT;
            count_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        COMPACT: begin
          if (scan_en) begin
            count_q <= count_d;
            if (count_d == WinLast) begin
              state_q <= CHECK;
            end
          end
        end
        CHECK: begin
          pass_q  <= (signature == golden);
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        DONE: begin
          if (start) begin
            state_q <= COMPACT;
            count_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign bit_count = count_q;

endmodule
